// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial add/subtract sequencer. A single full-adder cell is reused
//   for WIDTH clocks, one bit per clock, LSB first. On start the operands
//   are latched (B inverted for subtract) and the carry flip-flop is seeded
//   with cin, or with 1 for subtract. The result is published on the last
//   RUN edge, and then done pulses for one cycle.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     request a new operation (sampled only in IDLE)
//   sub       0: a + b + cin, 1: a - b (sampled with start)
//   a, b      WIDTH-bit operands (sampled with start)
//   cin       carry-in for add, ignored for subtract
//   busy      high in RUN and DONE
//   done      one-cycle completion pulse
//   sum       registered result, held until the next completion
//   cout      carry out of the MSB (subtract: 1 = no borrow)
//   overflow  two's-complement overflow of the last operation
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  // opa doubles as the result shift register: each consumed LSB frees the
  // MSB slot that receives the new sum bit.
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last;

  function automatic logic [1:0] full_adder(input logic x, input logic y,
                                            input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  assign {fa_co, fa_s} = full_adder(opa[0], opb[0], cy);
  assign last          = (state == RUN) && (cnt == LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  // Serial datapath: operand/result shifting, carry, bit counter, results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa      <= '0;
      opb      <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa <= a;
            opb <= sub ? ~b : b;
            cy  <= sub ? 1'b1 : cin;
            cnt <= '0;
          end
        end
        RUN: begin
          opa <= {fa_s, opa[WIDTH-1:1]};
          opb <= {1'b0, opb[WIDTH-1:1]};
          cy  <= fa_co;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            sum      <= {fa_s, opa[WIDTH-1:1]};
            cout     <= fa_co;
            // carry into the MSB (cy) differs from carry out of it
            overflow <= cy ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation from IDLE (called #1 after an edge) and check the
  // handshake timing and the result. Operands are scrambled while busy.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       input logic isub, input logic icin,
                       input logic [7:0] es, input logic ec, input logic eo,
                       input string tag);
    int lat;
    int bcnt;
    a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy@start"}, 32'(busy), 32'd1);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      sub = 1'($urandom);
      cin = 1'($urandom);
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'd8);
    chk({tag, " sum"}, 32'(sum), 32'(es));
    chk({tag, " cout"}, 32'(cout), 32'(ec));
    chk({tag, " overflow"}, 32'(overflow), 32'(eo));
    @(posedge clk); #1;
    chk({tag, " done pulse width"}, 32'(done), 32'd0);
    chk({tag, " busy after"}, 32'(busy), 32'd0);
    chk({tag, " busy cycles"}, 32'(bcnt), 32'd9);
  endtask

  logic [7:0] ha [3];
  logic [7:0] hb [3];
  logic [7:0] hs [3];

  initial begin
    reset = 1'b0; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("reset outputs", {27'd0, busy, done, cout, overflow, 1'b0} | 32'(sum), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("idle after reset", 32'(busy), 32'd0);

    // 1-2: add cases
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "add 5A+3C");
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add FF+01");
    do_op(8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, "add 00+00+cin");

    // 3: subtract cases (cin must be ignored)
    do_op(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, "sub 10-20");
    do_op(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, "sub 80-01");

    // 6: result hold with start low
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      chk("hold", {21'd0, busy, done, cout, overflow, sum}, {21'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7F});
    end

    // 4: start held high, operations accepted every 10 edges
    ha[0] = 8'h12; hb[0] = 8'h34; hs[0] = 8'h46;
    ha[1] = 8'hF0; hb[1] = 8'h20; hs[1] = 8'h10;
    ha[2] = 8'h7F; hb[2] = 8'h01; hs[2] = 8'h80;
    start = 1'b1;
    for (int e = 0; e < 30; e++) begin
      if (e % 10 == 0) begin
        a = ha[e/10]; b = hb[e/10]; sub = 1'b0; cin = 1'b0;
      end else begin
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      end
      @(posedge clk); #1;
      chk("stream done", 32'(done), 32'((e % 10) == 8));
      chk("stream busy", 32'(busy), 32'((e % 10) != 9));
      if (e % 10 == 8) chk("stream sum", 32'(sum), 32'(hs[e/10]));
    end
    start = 1'b0;
    chk("stream last overflow", 32'(overflow), 32'd1);

    // 5: asynchronous reset during the 4th RUN cycle
    a = 8'h01; b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midop reset busy", 32'(busy), 32'd0);
    chk("midop reset done", 32'(done), 32'd0);
    chk("midop reset sum", 32'(sum), 32'd0);
    chk("midop reset flags", {30'd0, cout, overflow}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no done in reset", 32'(done), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("no done after reset", 32'(done | busy), 32'd0);
    end
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "add after reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
